// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to a variable-latency memory,
// buffers in-order responses and presents one instruction plus its PC per cycle to IF.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);
    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = AW + 1;
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {FILL_RESET, FILL_RUN, FILL_DRAIN} fillState_t;

    fillState_t    fillState;
    logic [31:0]   fetchPc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] tagRdPtr;
    logic [AW-1:0] tagWrPtr;
    logic [31:0]   dataMem [DEPTH];
    logic [31:0]   pcMem   [DEPTH];
    logic [31:0]   tagMem  [DEPTH];

    logic          reqFire;
    logic          rspKeep;
    logic          popHead;
    logic [CW:0]   inUse;
    logic [CW-1:0] outstandingNext;
    logic [CW-1:0] discardNext;

    // Capacity covers both queued words and requests whose words have not come back yet.
    assign inUse           = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_valid   = (fillState != FILL_RESET) && (inUse < CAP) && !redirect_valid;
    assign mem_req_addr    = fetchPc;
    assign reqFire         = mem_req_valid && mem_req_ready;
    assign rspKeep         = mem_rsp_valid && (discard == '0) && !redirect_valid;
    assign popHead         = deq_ready && inst_valid && !redirect_valid;
    assign outstandingNext = outstanding + CW'(reqFire) - CW'(mem_rsp_valid);

    always_comb begin
        discardNext = discard;
        if (redirect_valid) begin
            discardNext = outstandingNext;
        end else if (mem_rsp_valid && (discard != '0)) begin
            discardNext = discard - CW'(1);
        end
    end

    // Head is read from registered storage only; empty queue shows zeros.
    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? dataMem[rdPtr] : '0;
    assign inst_pc    = inst_valid ? pcMem[rdPtr] : '0;
    assign inst_pc4   = inst_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            fillState   <= FILL_RESET;
            fetchPc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            tagRdPtr    <= '0;
            tagWrPtr    <= '0;
        end else begin
            outstanding <= outstandingNext;
            discard     <= discardNext;
            if (reqFire) begin
                tagWrPtr <= tagWrPtr + AW'(1);
            end
            // Tags are popped for every response, including discarded ones, to stay aligned.
            if (mem_rsp_valid) begin
                tagRdPtr <= tagRdPtr + AW'(1);
            end
            if (redirect_valid) begin
                fetchPc <= redirect_pc;
                count   <= '0;
                rdPtr   <= wrPtr;
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + 32'd4;
                end
                if (rspKeep) begin
                    wrPtr <= wrPtr + AW'(1);
                end
                if (popHead) begin
                    rdPtr <= rdPtr + AW'(1);
                end
                count <= count + CW'(rspKeep) - CW'(popHead);
            end
            case (fillState)
                FILL_RESET: fillState <= FILL_RUN;
                FILL_RUN,
                FILL_DRAIN: fillState <= (discardNext != '0) ? FILL_DRAIN : FILL_RUN;
                default:    fillState <= FILL_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reqFire) begin
            tagMem[tagWrPtr] <= fetchPc;
        end
        if (rspKeep) begin
            dataMem[wrPtr] <= mem_rsp_data;
            pcMem[wrPtr]   <= tagMem[tagRdPtr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_rsp_valid && (outstanding == '0)));
            assert (inUse <= CAP);
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized scoreboard bench for inst_prefetch_queue: a bench-side memory answers accepted
// fetches in order, and an epoch-tagged queue model predicts every IF-side output.
module tb_inst_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        deq_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready),
        .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          readyCyc;
    } memReq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } expEntry_t;

    memReq_t     pending[$];
    expEntry_t   expQ[$];
    int          epoch = 0;
    int          cyc = 0;
    int          lastReady = 0;
    int          acceptCnt = 0;
    int          nChecks = 0;
    int          nFail = 0;
    int          latMin = 1;
    int          latMax = 1;
    logic [31:0] modelPc = RESET_PC;
    logic [31:0] lastAcceptAddr = '0;
    bit          modelReady = 0;
    bit          postReset = 0;
    bit          wrapSeen = 0;
    bit          sRst = 1;
    bit          sRedir, sDeq, sAccept, sRsp;
    logic [31:0] sRpc, sAddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Monitor: sample inputs/outputs mid-cycle and compare against the model.
    always @(negedge clk) begin
        sRst    = rst;
        sRedir  = redirect_valid;
        sRpc    = redirect_pc;
        sDeq    = deq_ready;
        sAccept = (mem_req_valid === 1'b1) && mem_req_ready;
        sAddr   = mem_req_addr;
        sRsp    = mem_rsp_valid;
        if (modelReady) begin
            chk("inst_valid", inst_valid, expQ.size() != 0);
            if (expQ.size() != 0) begin
                chk("inst_pc", inst_pc, expQ[0].pc);
                chk("inst_out", inst_out, expQ[0].data);
                chk("inst_pc4", inst_pc4, expQ[0].pc + 32'd4);
            end
            if (postReset) begin
                chk("rst_inst_out", inst_out, 32'd0);
                chk("rst_inst_pc", inst_pc, 32'd0);
                chk("rst_inst_pc4", inst_pc4, 32'd4);
            end
            chk("mem_req_valid", mem_req_valid,
                !postReset && (expQ.size() + pending.size() < DEPTH) && !redirect_valid);
            if (mem_req_valid === 1'b1) begin
                chk("mem_req_addr", mem_req_addr, modelPc);
            end
        end
    end

    // Reference model and memory bookkeeping, committed on the clock edge.
    always @(posedge clk) begin
        memReq_t r;
        memReq_t n;
        int      lat;
        bit      doPop;
        if (sRst) begin
            expQ.delete();
            pending.delete();
            modelPc    = RESET_PC;
            postReset  = 1;
            modelReady = 1;
            acceptCnt  = 0;
            wrapSeen   = 0;
            lastReady  = 0;
            epoch++;
        end else begin
            postReset = 0;
            doPop = sDeq && (expQ.size() != 0);
            if (sRsp && (pending.size() != 0)) begin
                r = pending.pop_front();
                if (!sRedir && (r.epoch == epoch)) begin
                    expQ.push_back('{pc: r.addr, data: r.data});
                end
            end
            if (sRedir) begin
                expQ.delete();
                epoch++;
                modelPc = sRpc;
            end else if (doPop) begin
                void'(expQ.pop_front());
            end
            if (sAccept) begin
                lat = int'($urandom_range(latMax, latMin));
                n.readyCyc = (cyc + lat > lastReady) ? cyc + lat : lastReady;
                lastReady = n.readyCyc;
                n.addr  = sAddr;
                n.data  = $urandom();
                n.epoch = epoch;
                pending.push_back(n);
                if ((acceptCnt > 0) && (lastAcceptAddr == 32'hFFFF_FFFC) && (sAddr == 32'd0)) begin
                    wrapSeen = 1;
                end
                lastAcceptAddr = sAddr;
                acceptCnt++;
                modelPc = modelPc + 32'd4;
            end
        end
        cyc++;
    end

    // Memory: answers in request order once each entry's latency has elapsed.
    always @(posedge clk) begin
        #1;
        if ((pending.size() != 0) && (pending[0].readyCyc <= cyc)) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pending[0].data;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom();
        end
    end

    initial begin
        logic        got;
        logic [31:0] firstPc;
        repeat (2) step();

        // Streaming with 1-cycle memory and IF always consuming.
        latMin = 1; latMax = 1;
        mem_req_ready = 1'b1; deq_ready = 1'b1;
        doReset();
        repeat (20) step();

        // Fill to capacity with IF stalled, then release one slot.
        deq_ready = 1'b0;
        doReset();
        repeat (12) step();
        @(negedge clk);
        chk("full_req_valid", mem_req_valid, 1'b0);
        chk("full_accepts", acceptCnt, 4);
        step();
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        repeat (4) step();
        chk("refill_accepts", acceptCnt, 5);
        chk("refill_addr", lastAcceptAddr, 32'd16);

        // Redirect with two requests in flight on a 3-cycle memory.
        latMin = 3; latMax = 3;
        mem_req_ready = 1'b0; deq_ready = 1'b1;
        doReset();
        step(); mem_req_ready = 1'b1;
        step();
        step(); mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step(); mem_req_ready = 1'b1; redirect_valid = 1'b0;
        got = 1'b0; firstPc = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) begin
                got = 1'b1;
                firstPc = inst_pc;
                break;
            end
        end
        chk("redir_got_valid", got, 1'b1);
        chk("redir_first_pc", firstPc, 32'h0000_0100);

        // Redirect coinciding with a response and a dequeue.
        latMin = 1; latMax = 1;
        step();
        doReset();
        repeat (6) step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("coinc_inst_valid", inst_valid, 1'b0);
        chk("coinc_req_valid", mem_req_valid, 1'b1);
        chk("coinc_req_addr", mem_req_addr, 32'h0000_2000);

        // Reset asserted with three entries queued.
        step();
        deq_ready = 1'b0;
        doReset();
        repeat (5) step();
        @(negedge clk);
        chk("pre_rst_valid", inst_valid, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_inst_valid", inst_valid, 1'b0);
        chk("midrst_req_valid", mem_req_valid, 1'b0);
        step();
        @(negedge clk);
        chk("midrst_refetch_valid", mem_req_valid, 1'b1);
        chk("midrst_refetch_addr", mem_req_addr, RESET_PC);

        // Fetch address wraps past the top of the address space.
        step();
        latMin = 1; latMax = 2;
        deq_ready = 1'b1;
        doReset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        repeat (10) step();
        chk("wrap_seen", wrapSeen, 1'b1);

        // Randomized traffic: variable latency, stalls, redirects, occasional reset.
        latMin = 1; latMax = 4;
        for (int i = 0; i < 3000; i++) begin
            mem_req_ready  = ($urandom_range(3, 0) != 0);
            deq_ready      = (((i / 100) % 3) == 1) ? ($urandom_range(7, 0) == 0)
                                                     : ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_pc    = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF0
                                                         : ($urandom() & 32'h0000_FFFC);
            rst            = ($urandom_range(299, 0) == 0);
            step();
        end
        rst = 1'b0; redirect_valid = 1'b0; deq_ready = 1'b1; mem_req_ready = 1'b1;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
